// File: rtl/xcorr_scheduler.sv
// xcorr_scheduler: round-robin arbiter that time-shares one cross-correlation engine between mic pairs.
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   enable             allows new grants; a running job always finishes
//   req[NUM_PAIRS]     per-pair level request
//   gnt[NUM_PAIRS]     one-hot engine owner, zero when idle
//   eng_sel[2]         owner index for the engine input mux
//   eng_start          one-cycle engine start pulse
//   eng_done, eng_lag  engine completion pulse and its lag result
//   res_valid          one-cycle pulse on the completed pair's bit
//   res_lag            clamped lag of the last completed job
//   err_timeout        sticky watchdog abort flag
//   err_range          sticky out-of-range lag flag
//   busy               high whenever a job is in flight
module xcorr_scheduler #(
   parameter int NUM_PAIRS   = 2,
   parameter int LAG_W       = 6,
   parameter int MAX_LAG     = 60,
   parameter int TIMEOUT_CYC = 70000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic [NUM_PAIRS-1:0] req,
   output logic [NUM_PAIRS-1:0] gnt,
   output logic [1:0]           eng_sel,
   output logic                 eng_start,
   input  logic                 eng_done,
   input  logic [LAG_W-1:0]     eng_lag,
   output logic [NUM_PAIRS-1:0] res_valid,
   output logic [LAG_W-1:0]     res_lag,
   output logic                 err_timeout,
   output logic                 err_range,
   output logic                 busy
);
   localparam int CW = $clog2(TIMEOUT_CYC);
   typedef enum logic [2:0] {IDLE, GRANT, START, WAIT, DONE} state_t;
   state_t               state, state_nx;
   logic [1:0]           owner, rr_ptr, pick, cand, nxt_ptr;
   logic                 found, expire, lag_over;
   logic [CW-1:0]        wdog;
   logic [NUM_PAIRS-1:0] owner_oh;
   logic [LAG_W-1:0]     lag_clamp;

   assign nxt_ptr   = 2'((int'(owner) + 1) % NUM_PAIRS);
   assign lag_over  = eng_lag > LAG_W'(MAX_LAG);
   assign lag_clamp = lag_over ? LAG_W'(MAX_LAG) : eng_lag;

   // first requester at or after rr_ptr, wrapping modulo NUM_PAIRS
   always_comb begin
      pick  = rr_ptr;
      found = 1'b0;
      cand  = '0;
      for (int i = 0; i < NUM_PAIRS; i++) begin
         cand = 2'((int'(rr_ptr) + i) % NUM_PAIRS);
         if (!found && (req & (NUM_PAIRS'(1) << cand)) != '0) begin
            pick  = cand;
            found = 1'b1;
         end
      end
   end

   // the abort fires on the edge where the watchdog would reach TIMEOUT_CYC-1,
   // so IDLE is entered exactly TIMEOUT_CYC cycles after the start pulse
   always_comb begin
      state_nx  = state;
      busy      = state != IDLE;
      owner_oh  = NUM_PAIRS'(1) << owner;
      gnt       = busy ? owner_oh : '0;
      eng_sel   = busy ? owner : 2'd0;
      eng_start = state == START;
      res_valid = (state == DONE) ? owner_oh : '0;
      expire    = state == WAIT && !eng_done && wdog == CW'(TIMEOUT_CYC - 2);
      case (state)
         IDLE:    state_nx = (enable && found) ? GRANT : IDLE;
         GRANT:   state_nx = START;
         START:   state_nx = WAIT;
         WAIT:    state_nx = eng_done ? DONE : expire ? IDLE : WAIT;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         owner       <= '0;
         rr_ptr      <= '0;
         wdog        <= '0;
         res_lag     <= '0;
         err_timeout <= 1'b0;
         err_range   <= 1'b0;
      end else begin
         state <= state_nx;
         wdog  <= (state == START) ? '0 : (state == WAIT) ? wdog + 1'b1 : wdog;
         if (state == IDLE && state_nx == GRANT)
            owner <= pick;
         // result is captured on the done edge so it is visible in the DONE cycle
         if (state == WAIT && eng_done) begin
            res_lag <= lag_clamp;
            if (lag_over)
               err_range <= 1'b1;
         end
         if (expire)
            err_timeout <= 1'b1;
         if (expire || state == DONE)
            rr_ptr <= nxt_ptr;
      end
   end
endmodule
